conv2d_kxk_stream: RTL and testbench

Streaming 2-D convolution engine with a run-time-loadable KSIZE×KSIZE signed fixed-point kernel, zero padding ("same" output size), stride decimation, output saturation and optional ReLU. It takes one raster-order pixel per accepted cycle from the upstream feature FIFO. It writes results to the downstream output FIFO. It replaces the fixed-size kernel convolvers in the tiny-model datapath. It adds its own line buffering, an end-of-frame drain, an input back-pressure handshake and a serial coefficient load port.

---
 rtl/conv2d_kxk_stream.sv | 190 +++++++++++++++++++
 tb/tb_conv2d_kxk_stream.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_kxk_stream.sv
// Streaming KSIZE x KSIZE signed fixed-point 2-D convolution with zero padding,
// stride decimation, output saturation, optional ReLU and an end-of-frame drain.
module conv2d_kxk_stream #(
  parameter int IMG_Width  = 28,
  parameter int IMG_Height = 28,
  parameter int Datawidth  = 16,
  parameter int Frac       = 8,
  parameter int KSIZE      = 3,
  parameter int Stride     = 1,
  parameter bit ReLU       = 1'b1
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic [Datawidth-1:0] In,
  input  logic                 Valid_IN,
  output logic                 In_Ready,
  input  logic [Datawidth-1:0] K_In,
  input  logic                 K_Load,
  output logic [Datawidth-1:0] Out,
  output logic                 Valid_OUT,
  output logic                 Frame_Done,
  output logic                 Busy
);
  localparam int P    = (KSIZE - 1) / 2;
  localparam int NTAP = KSIZE * KSIZE;
  localparam int NPIX = IMG_Width * IMG_Height;
  localparam int D    = P * IMG_Width + P;
  localparam int PW   = 2 * Datawidth;
  localparam int SW   = PW + $clog2(NTAP);
  localparam int CW   = $clog2(NPIX);
  localparam int DCW  = $clog2(D);
  localparam int RW   = $clog2(IMG_Height);
  localparam int XW   = $clog2(IMG_Width);
  localparam int KW   = $clog2(NTAP);
  localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) <<< (Datawidth - 1)) - SW'(1);
  localparam logic signed [SW-1:0] SAT_MIN = -(SW'(1) <<< (Datawidth - 1));

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                      state;
  logic [CW-1:0]               in_cnt;
  logic [DCW-1:0]              drain_cnt;
  logic [RW-1:0]               out_r, r0;
  logic [XW-1:0]               out_c, c0, lb_ptr;
  logic [KW-1:0]               kptr;
  logic                        accept, shift, eval;
  logic signed [Datawidth-1:0] shift_px;
  logic signed [Datawidth-1:0] coef   [NTAP];
  logic signed [Datawidth-1:0] win    [KSIZE][KSIZE];
  logic signed [Datawidth-1:0] lbuf   [KSIZE-1][IMG_Width];
  logic signed [Datawidth-1:0] col_in [KSIZE];
  logic signed [Datawidth-1:0] tap    [NTAP];
  logic signed [PW-1:0]        prod   [NTAP];
  logic signed [SW-1:0]        sum_c, sum_r, shr;
  logic signed [Datawidth-1:0] res;
  logic                        v0, v1, v2, keep0, keep1, keep2, last0, last1, last2;

  assign accept   = Valid_IN & In_Ready;
  assign shift    = accept | (state == DRAIN);
  assign eval     = accept ? (in_cnt >= CW'(D)) : (state == DRAIN);
  assign shift_px = accept ? $signed(In) : '0;
  assign Busy     = (state != IDLE) | v0 | v1 | v2;

  // NOTE: sequential state uses <= only, so every block samples pre-edge values.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state     <= IDLE;
      In_Ready  <= 1'b1;
      in_cnt    <= '0;
      drain_cnt <= '0;
      out_r     <= '0;
      out_c     <= '0;
      lb_ptr    <= '0;
    end else begin
      if (accept) begin
        if (in_cnt == CW'(NPIX - 1)) begin
          state     <= DRAIN;
          In_Ready  <= 1'b0;
          in_cnt    <= '0;
          drain_cnt <= '0;
        end else begin
          state  <= STREAM;
          in_cnt <= in_cnt + 1'b1;
        end
      end else if (state == DRAIN) begin
        if (drain_cnt == DCW'(D - 1)) begin
          state    <= IDLE;
          In_Ready <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt + 1'b1;
        end
      end
      if (shift) lb_ptr <= (lb_ptr == XW'(IMG_Width - 1)) ? '0 : lb_ptr + 1'b1;
      if (eval) begin
        if (out_c == XW'(IMG_Width - 1)) begin
          out_c <= '0;
          out_r <= (out_r == RW'(IMG_Height - 1)) ? '0 : out_r + 1'b1;
        end else begin
          out_c <= out_c + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      kptr <= '0;
      for (int t = 0; t < NTAP; t++) coef[t] <= '0;
    end else if (K_Load && !Busy && !Valid_IN) begin
      coef[kptr] <= $signed(K_In);
      kptr       <= (kptr == KW'(NTAP - 1)) ? '0 : kptr + 1'b1;
    end
  end

  // NOTE: line buffers and window are never reset; out-of-frame taps are masked below.
  always_ff @(posedge CLK) begin
    if (shift) begin
      lbuf[0][lb_ptr] <= shift_px;
      for (int k = 1; k < KSIZE - 1; k++) lbuf[k][lb_ptr] <= lbuf[k-1][lb_ptr];
      for (int i = 0; i < KSIZE; i++) begin
        for (int j = 0; j < KSIZE - 1; j++) win[i][j] <= win[i][j+1];
        win[i][KSIZE-1] <= col_in[i];
      end
    end
  end

  // NOTE: every always_comb output is assigned a default first, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < KSIZE; i++) col_in[i] = '0;
    col_in[KSIZE-1] = shift_px;
    for (int k = 0; k < KSIZE - 1; k++) col_in[KSIZE-2-k] = lbuf[k][lb_ptr];
  end

  // Tap (i,j) of the window registered for position (r0,c0) is pixel (r0+i-P, c0+j-P).
  always_comb begin
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE; j++) begin
        tap[i*KSIZE+j] = '0;
        if (int'(r0) + i >= P && int'(r0) + i - P < IMG_Height &&
            int'(c0) + j >= P && int'(c0) + j - P < IMG_Width)
          tap[i*KSIZE+j] = win[i][j];
      end
    end
    keep0 = (int'(r0) % Stride == 0) && (int'(c0) % Stride == 0);
    last0 = (r0 == RW'(IMG_Height - 1)) && (c0 == XW'(IMG_Width - 1));
  end

  always_comb begin
    sum_c = '0;
    for (int t = 0; t < NTAP; t++) sum_c += SW'(prod[t]);
  end

  always_comb begin
    shr = sum_r >>> Frac;
    if (shr > SAT_MAX)      res = SAT_MAX[Datawidth-1:0];
    else if (shr < SAT_MIN) res = SAT_MIN[Datawidth-1:0];
    else                    res = shr[Datawidth-1:0];
    if (ReLU && res[Datawidth-1]) res = '0;
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      {v0, v1, v2, keep1, keep2, last1, last2} <= '0;
      r0         <= '0;
      c0         <= '0;
      sum_r      <= '0;
      Out        <= '0;
      Valid_OUT  <= 1'b0;
      Frame_Done <= 1'b0;
      for (int t = 0; t < NTAP; t++) prod[t] <= '0;
    end else begin
      v0 <= eval;
      if (eval) begin
        r0 <= out_r;
        c0 <= out_c;
      end
      v1    <= v0;
      keep1 <= keep0;
      last1 <= last0;
      for (int t = 0; t < NTAP; t++) prod[t] <= PW'(tap[t]) * PW'(coef[t]);
      v2    <= v1;
      keep2 <= keep1;
      last2 <= last1;
      sum_r <= sum_c;
      Valid_OUT  <= v2 & keep2;
      Frame_Done <= v2 & last2;
      if (v2 & keep2) Out <= res;
    end
  end
endmodule

// File: tb/tb_conv2d_kxk_stream.sv
// Directed bench for conv2d_kxk_stream: four instances with different frame size,
// fixed-point format, stride and ReLU settings share the stimulus buses.
`timescale 1ns/1ps
module tb_conv2d_kxk_stream;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din   = '0;
  logic [15:0] kin   = '0;
  logic        vin   [4];
  logic        kld   [4];
  logic        rdy   [4];
  logic [15:0] dout  [4];
  logic        vout  [4];
  logic        fdone [4];
  logic        busy  [4];

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: 4x4 Q8 identity/back-to-back/reset, 1: 4x4 Q0, 2: 4x4 Q0 stride 2, 3: 3x3 Q0 no ReLU
  conv2d_kxk_stream #(.IMG_Width(4), .IMG_Height(4), .Datawidth(16), .Frac(8), .KSIZE(3),
                      .Stride(1), .ReLU(1'b1)) u_q8 (
    .CLK(clk), .CLR(rst_n), .In(din), .Valid_IN(vin[0]), .In_Ready(rdy[0]), .K_In(kin),
    .K_Load(kld[0]), .Out(dout[0]), .Valid_OUT(vout[0]), .Frame_Done(fdone[0]), .Busy(busy[0]));
  conv2d_kxk_stream #(.IMG_Width(4), .IMG_Height(4), .Datawidth(16), .Frac(0), .KSIZE(3),
                      .Stride(1), .ReLU(1'b1)) u_q0 (
    .CLK(clk), .CLR(rst_n), .In(din), .Valid_IN(vin[1]), .In_Ready(rdy[1]), .K_In(kin),
    .K_Load(kld[1]), .Out(dout[1]), .Valid_OUT(vout[1]), .Frame_Done(fdone[1]), .Busy(busy[1]));
  conv2d_kxk_stream #(.IMG_Width(4), .IMG_Height(4), .Datawidth(16), .Frac(0), .KSIZE(3),
                      .Stride(2), .ReLU(1'b1)) u_s2 (
    .CLK(clk), .CLR(rst_n), .In(din), .Valid_IN(vin[2]), .In_Ready(rdy[2]), .K_In(kin),
    .K_Load(kld[2]), .Out(dout[2]), .Valid_OUT(vout[2]), .Frame_Done(fdone[2]), .Busy(busy[2]));
  conv2d_kxk_stream #(.IMG_Width(3), .IMG_Height(3), .Datawidth(16), .Frac(0), .KSIZE(3),
                      .Stride(1), .ReLU(1'b0)) u_sat (
    .CLK(clk), .CLR(rst_n), .In(din), .Valid_IN(vin[3]), .In_Ready(rdy[3]), .K_In(kin),
    .K_Load(kld[3]), .Out(dout[3]), .Valid_OUT(vout[3]), .Frame_Done(fdone[3]), .Busy(busy[3]));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Output monitor for the selected instance; append-only, tests index from a mark.
  int sel = 0;
  int outq[$];
  int outcyc[$];
  int fd_cnt = 0, fd_at = 0, fd_cyc = 0;
  int obase = 0, fbase = 0;
  always @(negedge clk) begin
    if (vout[sel]) begin
      outq.push_back(int'($signed(dout[sel])));
      outcyc.push_back(cyc);
    end
    if (fdone[sel]) begin
      fd_cnt++;
      fd_at  = outq.size();
      fd_cyc = cyc;
    end
  end

  task automatic mark(input int s);
    sel   = s;
    obase = outq.size();
    fbase = fd_cnt;
  endtask

  int frame_px[$];
  int waits[$];
  int acc_edge[$];

  task automatic make_frame(input int n, input int base, input int step);
    for (int i = 0; i < n; i++) frame_px.push_back(base + i * step);
  endtask

  task automatic load_kernel(input int s, input int centre, input int other);
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      kin    = 16'((t == 4) ? centre : other);
      kld[s] = 1'b1;
      @(negedge clk);
      kld[s] = 1'b0;
    end
  endtask

  task automatic push_px(input int s, input int p, output int waited);
    waited = 0;
    @(negedge clk);
    din    = 16'(p);
    vin[s] = 1'b1;
    while (!rdy[s] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // Streams frame_px with Valid_IN held high; pulses K_Load alongside pixel kld_at.
  task automatic send_frame(input int s, input int kld_at);
    int w;
    waits.delete();
    acc_edge.delete();
    foreach (frame_px[i]) begin
      push_px(s, frame_px[i], w);
      waits.push_back(w);
      acc_edge.push_back(cyc + 1);
      if (i == kld_at) begin
        kin    = 16'h7fff;
        kld[s] = 1'b1;
      end else begin
        kld[s] = 1'b0;
      end
    end
    @(negedge clk);
    vin[s] = 1'b0;
    kld[s] = 1'b0;
    frame_px.delete();
  endtask

  task automatic wait_idle(input int s);
    int n = 0;
    @(negedge clk);
    while (busy[s] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(busy[s]), 0);
    repeat (2) @(negedge clk);
  endtask

  int exp_ones [16] = '{4, 6, 6, 4, 6, 9, 9, 6, 6, 9, 9, 6, 4, 6, 6, 4};
  int exp_s2   [4]  = '{4, 6, 6, 9};

  initial begin
    int w;
    for (int s = 0; s < 4; s++) begin
      vin[s] = 1'b0;
      kld[s] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("rst_ready%0d", s), int'(rdy[s]), 1);
      check($sformatf("rst_busy%0d", s), int'(busy[s]), 0);
      check($sformatf("rst_vout%0d", s), int'(vout[s]), 0);
      check($sformatf("rst_fdone%0d", s), int'(fdone[s]), 0);
      check($sformatf("rst_out%0d", s), int'(dout[s]), 0);
    end
    rst_n = 1'b1;

    // Identity kernel, pixels 1..16
    mark(0);
    load_kernel(0, 256, 0);
    make_frame(16, 1, 1);
    send_frame(0, -1);
    wait_idle(0);
    check("id_count", outq.size() - obase, 16);
    for (int k = 0; k < 16; k++) check($sformatf("id_out%0d", k), outq[obase + k], k + 1);
    check("id_fd_count", fd_cnt - fbase, 1);
    check("id_fd_with_16th", fd_at - obase, 16);
    check("id_fd_cycle", fd_cyc, outcyc[obase + 15]);

    // All-ones kernel on an all-ones frame
    mark(1);
    load_kernel(1, 1, 1);
    make_frame(16, 1, 0);
    send_frame(1, -1);
    wait_idle(1);
    check("ones_count", outq.size() - obase, 16);
    for (int k = 0; k < 16; k++) check($sformatf("ones_out%0d", k), outq[obase + k], exp_ones[k]);
    check("ones_latency", outcyc[obase] - acc_edge[5], 3);

    // Stride 2
    mark(2);
    load_kernel(2, 1, 1);
    make_frame(16, 1, 0);
    send_frame(2, -1);
    wait_idle(2);
    check("s2_count", outq.size() - obase, 4);
    for (int k = 0; k < 4; k++) check($sformatf("s2_out%0d", k), outq[obase + k], exp_s2[k]);
    check("s2_fd_count", fd_cnt - fbase, 1);
    check("s2_fd_after_kept", fd_at - obase, 4);
    check("s2_fd_position", fd_cyc - outcyc[obase + 3], 5);

    // Saturation, ReLU off (3x3 frame)
    mark(3);
    load_kernel(3, 1, 1);
    make_frame(9, 32767, 0);
    send_frame(3, -1);
    wait_idle(3);
    check("satp_count", outq.size() - obase, 9);
    check("satp_centre", outq[obase + 4], 32767);
    mark(3);
    load_kernel(3, -1, -1);
    make_frame(9, 32767, 0);
    send_frame(3, -1);
    wait_idle(3);
    check("satn_centre", outq[obase + 4], -32768);

    // Negative result with ReLU on
    mark(1);
    load_kernel(1, -1, -1);
    make_frame(16, 32767, 0);
    send_frame(1, -1);
    wait_idle(1);
    check("relu_count", outq.size() - obase, 16);
    check("relu_corner", outq[obase], 0);
    check("relu_interior", outq[obase + 5], 0);

    // Back-to-back frames with a K_Load pulse while busy
    mark(0);
    make_frame(16, 1, 1);
    make_frame(16, 101, 1);
    send_frame(0, 20);
    wait_idle(0);
    check("b2b_first_wait", waits[0], 0);
    check("b2b_last_wait", waits[15], 0);
    check("b2b_drain_cycles", waits[16], 5);
    check("b2b_count", outq.size() - obase, 32);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("b2b_a%0d", k), outq[obase + k], k + 1);
      check($sformatf("b2b_b%0d", k), outq[obase + 16 + k], k + 101);
    end
    check("b2b_fd_count", fd_cnt - fbase, 2);

    // Reset mid-frame
    mark(0);
    make_frame(7, 1, 1);
    foreach (frame_px[i]) push_px(0, frame_px[i], w);
    frame_px.delete();
    @(negedge clk);
    vin[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_clr_vout", int'(vout[0]), 1);
    check("pre_clr_out", int'(dout[0]), 1);
    rst_n = 1'b0;
    #1;
    check("clr_vout", int'(vout[0]), 0);
    check("clr_busy", int'(busy[0]), 0);
    check("clr_ready", int'(rdy[0]), 1);
    check("clr_out", int'(dout[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mark(0);
    make_frame(16, 1, 1);
    send_frame(0, -1);
    wait_idle(0);
    check("post_clr_count", outq.size() - obase, 16);
    for (int k = 0; k < 16; k++) check($sformatf("post_clr_out%0d", k), outq[obase + k], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
